pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM and MEM/WB registers).
- Compares the source registers needed by the D-stage instruction (Tuse) against the pending destinations in E and M (Tnew), and generates PC/IF-ID hold plus an ID/EX bubble.
- Sequences the multiply/divide unit with a busy countdown, so any HI/LO or MD instruction in D waits until the unit is idle.
- Keeps a saturating stall-cycle counter and a sticky MD protocol-error flag for debug.

Parameters:
- MULT_LAT, 5, busy cycles after a mult/multu start.
- DIV_LAT, 10, busy cycles after a div/divu start.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rs_D  in  5  rs field of the D-stage instruction.
- rt_D  in  5  rt field of the D-stage instruction.
- use_rs_D  in  1  D-stage instruction reads rs.
- use_rt_D  in  1  D-stage instruction reads rt.
- tuse_rs_D  in  2  cycles until rs is consumed (0 = D, 1 = E, 2 = M).
- tuse_rt_D  in  2  same, for rt.
- md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- a3_E  in  5  destination register in E (0 = none).
- tnew_E  in  2  cycles until the E result exists (load 2, ALU 1, link 0).
- a3_M  in  5  destination register in M.
- tnew_M  in  2  cycles until the M result exists (load 1, else 0).
- md_start_E  in  1  one-cycle pulse: MD operation enters E this cycle.
- md_div_E  in  1  1 = div/divu, 0 = mult/multu; qualified by md_start_E.
- stall  out  1  freeze PC and the IF/ID register.
- flush_E  out  1  load a bubble (all-zero IR) into the ID/EX register.
- md_busy  out  1  MD unit busy.
- md_cnt  out  4  remaining MD busy cycles.
- stall_cnt  out  CNT_W  total stall cycles since reset, saturating.
- md_err  out  1  sticky: md_start_E seen while md_cnt != 0.

Behaviour:
- Reset, asynchronous on reset = 0: md_cnt = 0, stall_cnt = 0, md_err = 0. With md_start_E = 0 and no operand hazard, stall, flush_E and md_busy are all 0.
- Operand hazard, combinational, checked per operand X in {rs, rt}:
  - stall_E_X = use_X_D & (X_D != 0) & (X_D == a3_E) & (tuse_X_D < tnew_E).
  - stall_M_X = the same expression using a3_M and tnew_M.
- MD hazard: stall_md = md_use_D & md_busy.
- stall = any operand hazard | stall_md. flush_E = stall. Both are combinational and take effect in the same cycle.
- md_busy = md_start_E | (md_cnt != 0). A start blocks the instruction behind it in the same cycle.
- MD counter, at posedge clk, in priority order:
  - md_start_E: load MULT_LAT or DIV_LAT (selected by md_div_E).
  - else md_cnt != 0: decrement by 1.
  - else: hold 0.
- MD timing:
  - mult started in cycle t: md_busy high in t..t+MULT_LAT; an mflo in D stalls through cycle t+MULT_LAT.
  - div: the same with DIV_LAT.
- md_start_E while md_cnt != 0:
  - Illegal, because issue should already be stalled.
  - The counter reloads (the latest start wins).
  - md_err sets and stays at 1 until reset.
- stall_cnt: at posedge, +1 when stall = 1; saturates at 2^CNT_W − 1 with no wrap.
- Register $0 never causes a stall.
- tnew = 0 never stalls, because the forwarding path covers it.
- An E hazard and an M hazard at once still give a single stall cycle per clock; the stall releases once every condition is clear.
- Reset asserted mid-countdown: md_cnt clears immediately (asynchronously), so md_busy drops unless md_start_E is high.
- No other internal state exists. The stall/flush outputs depend only on current inputs and md_cnt.

Test Plan:
1. lw $1 in E (a3_E = 1, tnew_E = 2); addu using $1 in D (tuse_rs = 1) -> stall = 1 and flush_E = 1 for 1 cycle. Next cycle, a3_M = 1, tnew_M = 1 -> stall = 0. stall_cnt = 1.
2. lw $1 in E; beq using $1 in D (tuse = 0) -> 2 consecutive stall cycles (E, then M with tnew_M = 1). stall_cnt = 2.
3. A3 = 0 in E with tnew_E = 2, rs_D = 0, use_rs_D = 1 -> stall = 0.
4. md_start_E with md_div_E = 0 at cycle t, then mflo held in D -> md_cnt reads 5,4,3,2,1,0 on successive cycles. stall high t..t+5 (6 cycles); stall = 0 at t+6.
5. div start, then reset pulled low at md_cnt = 7 -> md_cnt = 0, md_busy = 0 and stall_cnt = 0 immediately, without waiting for a clock edge.
6. Second md_start_E when md_cnt = 3 -> md_cnt reloads to 5 (mult) or 10 (div); md_err = 1 and stays 1. Force stall high for 70000 cycles with CNT_W = 16 -> stall_cnt saturates at 65535.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - D/E/M hazard inputs and stall/MD status outputs
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_D;
    logic [4:0]       rt_D;
    logic             use_rs_D;
    logic             use_rt_D;
    logic [1:0]       tuse_rs_D;
    logic [1:0]       tuse_rt_D;
    logic             md_use_D;
    logic [4:0]       a3_E;
    logic [1:0]       tnew_E;
    logic [4:0]       a3_M;
    logic [1:0]       tnew_M;
    logic             md_start_E;
    logic             md_div_E;
    logic             stall;
    logic             flush_E;
    logic             md_busy;
    logic [3:0]       md_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             md_err;

    modport master (
        output rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
               a3_E, tnew_E, a3_M, tnew_M, md_start_E, md_div_E,
        input  stall, flush_E, md_busy, md_cnt, stall_cnt, md_err
    );

    modport slave (
        input  rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
               a3_E, tnew_E, a3_M, tnew_M, md_start_E, md_div_E,
        output stall, flush_E, md_busy, md_cnt, stall_cnt, md_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - Tuse/Tnew operand hazard, MD busy sequencing, stall statistics
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    logic [3:0]       r_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_md_err;

    logic w_stall_e_rs;
    logic w_stall_m_rs;
    logic w_stall_e_rt;
    logic w_stall_m_rt;
    logic w_md_busy;
    logic w_stall;

    // $0 never hazards; tnew of 0 is always covered by forwarding since tuse >= 0
    assign w_stall_e_rs = bus.use_rs_D && (bus.rs_D != 5'd0) && (bus.rs_D == bus.a3_E)
                          && (bus.tuse_rs_D < bus.tnew_E);
    assign w_stall_m_rs = bus.use_rs_D && (bus.rs_D != 5'd0) && (bus.rs_D == bus.a3_M)
                          && (bus.tuse_rs_D < bus.tnew_M);
    assign w_stall_e_rt = bus.use_rt_D && (bus.rt_D != 5'd0) && (bus.rt_D == bus.a3_E)
                          && (bus.tuse_rt_D < bus.tnew_E);
    assign w_stall_m_rt = bus.use_rt_D && (bus.rt_D != 5'd0) && (bus.rt_D == bus.a3_M)
                          && (bus.tuse_rt_D < bus.tnew_M);

    assign w_md_busy = bus.md_start_E || (r_md_cnt != 4'd0);
    assign w_stall   = w_stall_e_rs || w_stall_m_rs || w_stall_e_rt || w_stall_m_rt
                       || (bus.md_use_D && w_md_busy);

    // A start while still counting is a protocol error; the newest start still wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= 4'd0;
            r_md_err <= 1'b0;
        end else begin
            if (bus.md_start_E) begin
                r_md_cnt <= bus.md_div_E ? 4'(DIV_LAT) : 4'(MULT_LAT);
                if (r_md_cnt != 4'd0)
                    r_md_err <= 1'b1;
            end else if (r_md_cnt != 4'd0) begin
                r_md_cnt <= r_md_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign bus.stall     = w_stall;
    assign bus.flush_E   = w_stall;
    assign bus.md_busy   = w_md_busy;
    assign bus.md_cnt    = r_md_cnt;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.md_err    = r_md_err;
endmodule
